amo_multi_unit: RTL and testbench

- Next-generation shared atomic unit for multi-agent configurations (several load-store units or harts).
- Keeps one LR reservation slot per agent instead of a single global reservation.
- Snoops committed stores, so a write by one agent kills matching reservations held by the others.
- Replaces the combinational RMW path with a round-robin-arbitrated, registered ALU stage using valid/ready handshakes on both request and response.

---
 rtl/amo_multi_unit.sv | 183 ++++++++++++++++++
 tb/tb_amo_multi_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_multi_unit.sv
// Shared multi-agent atomic unit: per-agent LR reservations with store snooping,
// plus a round-robin arbitrated, registered AMO ALU. Optional macro: AMO_RESERVATION_TIMEOUT_EN.
package riscv_types;
  typedef enum logic [3:0] {
    AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND, AMO_OR,
    AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU
  } amo_t;
endpackage

module amo_multi_unit
  import riscv_types::*;
#(
  parameter int NUM_UNITS         = 3,
  parameter int XLEN              = 32,
  parameter int RESERVATION_WORDS = 4,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_UNITS-1:0]           set_reservation,
  input  logic [NUM_UNITS-1:0]           clear_reservation,
  input  logic [NUM_UNITS-1:0][XLEN-1:0] res_addr,
  output logic [NUM_UNITS-1:0]           reservation_valid,
  input  logic [NUM_UNITS-1:0]           store_commit,
  input  logic [NUM_UNITS-1:0][XLEN-1:0] store_addr,
  input  logic [NUM_UNITS-1:0]           req_valid,
  output logic [NUM_UNITS-1:0]           req_ready,
  input  amo_t [NUM_UNITS-1:0]           req_op,
  input  logic [NUM_UNITS-1:0][XLEN-1:0] req_rs1,
  input  logic [NUM_UNITS-1:0][XLEN-1:0] req_rs2,
  output logic [NUM_UNITS-1:0]           rsp_valid,
  input  logic [NUM_UNITS-1:0]           rsp_ready,
  output logic [XLEN-1:0]                rsp_data
);

  localparam int GRAN_LSB = 2 + $clog2(RESERVATION_WORDS);
  localparam int RES_W    = XLEN - GRAN_LSB;
  localparam int PTR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  if (NUM_UNITS < 1 || NUM_UNITS > 8 || TIMEOUT_CYCLES < 2 ||
      (RESERVATION_WORDS & (RESERVATION_WORDS - 1)) != 0) begin : g_param_check
    $error("amo_multi_unit: illegal parameterisation");
  end

  function automatic logic [RES_W-1:0] f_gran(input logic [XLEN-1:0] addr);
    return addr[XLEN-1 -: RES_W];
  endfunction

  function automatic logic signed [XLEN-1:0] f_amo(input amo_t op,
                                                   input logic signed [XLEN-1:0] a,
                                                   input logic signed [XLEN-1:0] b);
    case (op)
      AMO_SWAP: return b;
      AMO_ADD:  return a + b;
      AMO_XOR:  return a ^ b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_MIN:  return (a < b) ? a : b;
      AMO_MAX:  return (a > b) ? a : b;
      AMO_MINU: return ($unsigned(a) < $unsigned(b)) ? a : b;
      AMO_MAXU: return ($unsigned(a) > $unsigned(b)) ? a : b;
      default:  return b;
    endcase
  endfunction

  logic [NUM_UNITS-1:0]            r_slot_vld;
  logic [NUM_UNITS-1:0][RES_W-1:0] r_slot_addr;
  logic [NUM_UNITS-1:0]            w_kill;
  logic                            w_unused_lsb;

  // Granule offset bits never take part in reservation matching.
  always_comb begin
    w_unused_lsb = 1'b0;
    w_kill       = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_unused_lsb = w_unused_lsb ^ (^res_addr[i][GRAN_LSB-1:0]) ^ (^store_addr[i][GRAN_LSB-1:0]);
      for (int j = 0; j < NUM_UNITS; j++) begin
        if (j != i && store_commit[j] && f_gran(store_addr[j]) == r_slot_addr[i])
          w_kill[i] = 1'b1;
      end
    end
  end

`ifdef AMO_RESERVATION_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_UNITS-1:0][CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (rst)
        r_tmo_cnt[i] <= '0;
      else if (set_reservation[i])
        r_tmo_cnt[i] <= CNT_W'(TIMEOUT_CYCLES);
      else if (!r_slot_vld[i] || clear_reservation[i] || w_kill[i] || r_tmo_cnt[i] == '0)
        r_tmo_cnt[i] <= '0;
      else
        r_tmo_cnt[i] <= r_tmo_cnt[i] - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (rst)
        r_slot_vld[i] <= 1'b0;
      else if (set_reservation[i])
        r_slot_vld[i] <= 1'b1;
      else if (clear_reservation[i] || w_kill[i])
        r_slot_vld[i] <= 1'b0;
`ifdef AMO_RESERVATION_TIMEOUT_EN
      // Counter at 1 means it reaches 0 on this edge, so the slot expires now.
      else if (r_slot_vld[i] && r_tmo_cnt[i] <= CNT_W'(1))
        r_slot_vld[i] <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_UNITS; i++)
      if (set_reservation[i]) r_slot_addr[i] <= f_gran(res_addr[i]);
  end

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++)
      reservation_valid[i] = r_slot_vld[i] && (r_slot_addr[i] == f_gran(res_addr[i]));
  end

  // ---- p0: round-robin arbitration and operand select ----
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_scan;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic [NUM_UNITS-1:0]   w_grant;
  logic                   w_gnt_any;
  logic                   w_out_free;
  logic [NUM_UNITS-1:0]   r_rsp_vld_p1;
  logic signed [XLEN-1:0] r_rsp_data_p1;

  assign w_out_free = ~|r_rsp_vld_p1 | (|(r_rsp_vld_p1 & rsp_ready));

  always_comb begin
    w_scan    = '0;
    w_gnt_idx = '0;
    w_grant   = '0;
    w_gnt_any = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      w_scan = PTR_W'((int'(r_ptr) + k) % NUM_UNITS);
      if (!w_gnt_any && w_out_free && req_valid[w_scan]) begin
        w_gnt_any        = 1'b1;
        w_gnt_idx        = w_scan;
        w_grant[w_scan]  = 1'b1;
      end
    end
  end

  assign req_ready = w_grant;

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_gnt_any)
      r_ptr <= PTR_W'((int'(w_gnt_idx) + 1) % NUM_UNITS);
  end

  // ---- p1: registered result, held until the owning agent consumes it ----
  always_ff @(posedge clk) begin
    if (rst)
      r_rsp_vld_p1 <= '0;
    else if (w_gnt_any)
      r_rsp_vld_p1 <= w_grant;
    else if (|(r_rsp_vld_p1 & rsp_ready))
      r_rsp_vld_p1 <= '0;
  end

  always_ff @(posedge clk) begin
    if (w_gnt_any)
      r_rsp_data_p1 <= f_amo(req_op[w_gnt_idx], $signed(req_rs1[w_gnt_idx]),
                             $signed(req_rs2[w_gnt_idx]));
  end

  assign rsp_valid = r_rsp_vld_p1;
  assign rsp_data  = $unsigned(r_rsp_data_p1);

endmodule

// File: tb/tb_amo_multi_unit.sv
// Scoreboard bench for amo_multi_unit: reservation slots, snooping, RR arbitration,
// AMO results, back-pressure and reset behaviour.
module tb_amo_multi_unit;
  import riscv_types::*;

  localparam int N = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           set_reservation, clear_reservation, store_commit;
  logic [N-1:0][31:0]     res_addr, store_addr, req_rs1, req_rs2;
  logic [N-1:0]           reservation_valid, req_valid, req_ready, rsp_valid, rsp_ready;
  amo_t [N-1:0]           req_op;
  logic [31:0]            rsp_data;

  amo_multi_unit #(.NUM_UNITS(N), .XLEN(32), .RESERVATION_WORDS(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .set_reservation(set_reservation), .clear_reservation(clear_reservation),
    .res_addr(res_addr), .reservation_valid(reservation_valid),
    .store_commit(store_commit), .store_addr(store_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          agent;
    logic [31:0] data;
  } exp_t;

  exp_t         sb[$];
  int           n_assert = 0;
  int           n_fail   = 0;
  int           m_ptr    = 0;
  logic         oneshot  = 1'b0;
  logic [N-1:0] drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_amo(input amo_t op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    case (op)
      AMO_SWAP: return b;
      AMO_ADD:  begin sum = {1'b0, a} + {1'b0, b}; return sum[31:0]; end
      AMO_XOR:  return a ^ b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_MIN:  return ($signed(a) <= $signed(b)) ? a : b;
      AMO_MAX:  return ($signed(a) >= $signed(b)) ? a : b;
      AMO_MINU: return (a <= b) ? a : b;
      AMO_MAXU: return (a >= b) ? a : b;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Pre-edge scoreboard step: check the in-flight response, predict the grant, push its result.
  task automatic sb_step();
    bit           free;
    int           g;
    logic [N-1:0] exp_ready;
    free = (sb.size() == 0) || rsp_ready[sb[0].agent];
    if (sb.size() > 0) begin
      check("rsp_valid", rsp_valid, 64'(1) << sb[0].agent);
      check("rsp_data", rsp_data, sb[0].data);
    end else begin
      check("rsp_idle", rsp_valid, 0);
    end
    g = -1;
    if (free)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    if (free && sb.size() > 0) void'(sb.pop_front());
    drop = '0;
    if (g >= 0) begin
      sb.push_back('{agent: g, data: model_amo(req_op[g], req_rs1[g], req_rs2[g])});
      m_ptr = (g + 1) % N;
      if (oneshot) drop[g] = 1'b1;
    end
  endtask

  task automatic cycle();
    bit in_rst;
    #1;
    in_rst = rst;
    drop   = '0;
    if (!in_rst) sb_step();
    @(posedge clk);
    #1;
    if (in_rst) begin
      sb.delete();
      m_ptr = 0;
    end
    req_valid = req_valid & ~drop;
  endtask

  task automatic check_rv(input string tag, input int idx, input logic exp);
    #1;
    check(tag, reservation_valid[idx], exp);
  endtask

  initial begin
    rst = 1'b1;
    set_reservation = '0; clear_reservation = '0; store_commit = '0;
    res_addr = '0; store_addr = '0; req_rs1 = '0; req_rs2 = '0;
    req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) req_op[i] = AMO_ADD;

    repeat (2) cycle();
    rst = 1'b0;
    #1;
    check("reset_resv", reservation_valid, 0);
    check("reset_rsp", rsp_valid, 0);
    check("reset_ready", req_ready, 0);

    // Reservation within and outside the 16-byte granule
    set_reservation[0] = 1'b1; res_addr[0] = 32'h1000_0004;
    cycle();
    set_reservation[0] = 1'b0; res_addr[0] = 32'h1000_000C;
    check_rv("resv_same_granule", 0, 1'b1);
    res_addr[0] = 32'h1000_0010;
    check_rv("resv_other_granule", 0, 1'b0);

    // Snoop kill by another agent, none by the owner
    set_reservation[0] = 1'b1; res_addr[0] = 32'h2000;
    cycle();
    set_reservation[0] = 1'b0;
    store_commit[1] = 1'b1; store_addr[1] = 32'h2008;
    check_rv("snoop_before", 0, 1'b1);
    cycle();
    store_commit = '0;
    check_rv("snoop_kill", 0, 1'b0);
    set_reservation[0] = 1'b1;
    cycle();
    set_reservation[0] = 1'b0;
    store_commit[0] = 1'b1; store_addr[0] = 32'h2008;
    cycle();
    store_commit = '0;
    check_rv("own_store_keeps", 0, 1'b1);

    // Set beats same-cycle snoop; set beats same-cycle clear
    set_reservation[2] = 1'b1; res_addr[2] = 32'h3000;
    store_commit[0] = 1'b1; store_addr[0] = 32'h3000;
    cycle();
    set_reservation = '0; store_commit = '0;
    check_rv("set_over_snoop", 2, 1'b1);
    store_commit[1] = 1'b1; store_addr[1] = 32'h3010;
    cycle();
    store_commit = '0;
    check_rv("snoop_other_granule", 2, 1'b1);
    store_commit[1] = 1'b1; store_addr[1] = 32'h300C;
    cycle();
    store_commit = '0;
    check_rv("snoop_kill_slot2", 2, 1'b0);
    set_reservation[1] = 1'b1; clear_reservation[1] = 1'b1; res_addr[1] = 32'h4000;
    cycle();
    set_reservation = '0; clear_reservation = '0;
    check_rv("set_over_clear", 1, 1'b1);
    clear_reservation[1] = 1'b1;
    cycle();
    clear_reservation = '0;
    check_rv("clear", 1, 1'b0);

    // Round-robin: all agents continuously request ADD wrap
    oneshot = 1'b0;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_op[i] = AMO_ADD; req_rs1[i] = 32'hFFFF_FFFF; req_rs2[i] = 32'h1;
    end
    req_valid = '1;
    repeat (9) cycle();
    req_valid = '0;
    repeat (2) cycle();

    // MIN vs MINU with response back-pressure
    oneshot = 1'b1;
    req_op[0] = AMO_MIN;  req_rs1[0] = 32'h8000_0000; req_rs2[0] = 32'h1;
    req_op[1] = AMO_MINU; req_rs1[1] = 32'h8000_0000; req_rs2[1] = 32'h1;
    req_valid = 3'b011;
    rsp_ready = '0;
    repeat (4) cycle();
    rsp_ready = '1;
    repeat (3) cycle();

    // Random traffic with random response stalls
    for (int c = 0; c < 60; c++) begin
      for (int a = 0; a < N; a++) begin
        if (!req_valid[a] && $urandom_range(0, 1) == 1) begin
          req_op[a]  = amo_t'($urandom_range(0, 8));
          req_rs1[a] = $urandom();
          req_rs2[a] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
          req_valid[a] = 1'b1;
        end
      end
      rsp_ready = N'($urandom());
      cycle();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) cycle();

    // Reset with a pending response and a live reservation
    set_reservation[0] = 1'b1; res_addr[0] = 32'h5000;
    req_op[1] = AMO_SWAP; req_rs1[1] = 32'h1111; req_rs2[1] = 32'h2222; req_valid[1] = 1'b1;
    rsp_ready = '0;
    cycle();
    set_reservation = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_rv("reset_drops_resv", 0, 1'b0);
    rsp_ready = '1;
    cycle();

    // Reservation lifetime
    set_reservation[0] = 1'b1; res_addr[0] = 32'h6000;
    cycle();
    set_reservation = '0;
`ifdef AMO_RESERVATION_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      check_rv("timeout_alive", 0, 1'b1);
      cycle();
    end
    check_rv("timeout_expired", 0, 1'b0);
`else
    repeat (100) cycle();
    check_rv("no_timeout", 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
